// File: rtl/reg_36_if.sv
// Bus bundle for the reg_36 register: load/count controls in, state out.
// The master drives the enables and load data; the slave owns Q and flags.
interface reg_36_if #(
    parameter int unsigned WIDTH = 36
);
    logic             set;
    logic [WIDTH-1:0] D;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] Q;
    logic             zero;
    logic             carry;
    logic             borrow;

    modport master (
        output set, D, inc, dec,
        input  Q, zero, carry, borrow
    );

    modport slave (
        input  set, D, inc, dec,
        output Q, zero, carry, borrow
    );
endinterface

// File: rtl/reg_36.sv
// General-purpose up/down register with parallel load.
// Load beats count; inc and dec together cancel; wrap pulses are registered.
module reg_36 #(
    parameter int unsigned      WIDTH     = 36,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic     clk,
    input logic     rst,
    reg_36_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             carry_q;
    logic             carry_d;
    logic             borrow_q;
    logic             borrow_d;

    // Next state: load has priority, then a single-direction count, else hold.
    always_comb begin
        q_d      = q_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (bus.set) begin
            q_d = bus.D;
        end else if (bus.inc && !bus.dec) begin
            q_d     = q_q + ONE;
            carry_d = &q_q;
        end else if (bus.dec && !bus.inc) begin
            q_d      = q_q - ONE;
            borrow_d = ~|q_q;
        end
    end

    // State register with asynchronous reset to RESET_VAL and cleared flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= RESET_VAL;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.zero   = (q_q == '0);
    assign bus.carry  = carry_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_reg_36.sv
// Self-checking bench for reg_36: directed vector table plus
// hand-written sequences for asynchronous reset behaviour.
module tb_reg_36;
    localparam int W = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_36_if #(.WIDTH(W)) bus ();

    reg_36 #(
        .WIDTH    (W),
        .RESET_VAL('0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string        name;
        logic         set;
        logic         inc;
        logic         dec;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         c;
        logic         b;
        logic         z;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(string nm, logic s, logic i, logic dd,
                       logic [W-1:0] d, logic [W-1:0] q,
                       logic c, logic b, logic z);
        vec_t v;
        v.name = nm; v.set = s; v.inc = i; v.dec = dd;
        v.d = d; v.q = q; v.c = c; v.b = b; v.z = z;
        vecs.push_back(v);
    endtask

    task automatic chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(string nm, logic [W-1:0] q,
                           logic c, logic b, logic z);
        chk({nm, ".Q"}, bus.Q, q);
        chk({nm, ".carry"}, {35'd0, bus.carry}, {35'd0, c});
        chk({nm, ".borrow"}, {35'd0, bus.borrow}, {35'd0, b});
        chk({nm, ".zero"}, {35'd0, bus.zero}, {35'd0, z});
    endtask

    task automatic drive(logic s, logic i, logic dd, logic [W-1:0] d);
        bus.set = s; bus.inc = i; bus.dec = dd; bus.D = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0);

        add("load_a5",   1, 0, 0, 36'hA5A5A5A5A, 36'hA5A5A5A5A, 0, 0, 0);
        add("hold_a5",   0, 0, 0, 36'h0,         36'hA5A5A5A5A, 0, 0, 0);
        add("load_10",   1, 0, 0, 36'h010,       36'h010,       0, 0, 0);
        add("inc_11",    0, 1, 0, 36'h0,         36'h011,       0, 0, 0);
        add("inc_12",    0, 1, 0, 36'h0,         36'h012,       0, 0, 0);
        add("inc_13",    0, 1, 0, 36'h0,         36'h013,       0, 0, 0);
        add("dec_12",    0, 0, 1, 36'h0,         36'h012,       0, 0, 0);
        add("load_ones", 1, 0, 0, ONES,          ONES,          0, 0, 0);
        add("inc_wrap",  0, 1, 0, 36'h0,         36'h0,         1, 0, 1);
        add("hold_zero", 0, 0, 0, 36'h0,         36'h0,         0, 0, 1);
        add("dec_wrap",  0, 0, 1, 36'h0,         ONES,          0, 1, 0);
        add("hold_ones", 0, 0, 0, 36'h0,         ONES,          0, 0, 0);
        add("set_prio",  1, 1, 1, 36'h5,         36'h5,         0, 0, 0);
        add("inc_dec",   0, 1, 1, 36'h0,         36'h5,         0, 0, 0);
        add("load_zero", 1, 0, 1, 36'h0,         36'h0,         0, 0, 1);
        add("dec_wrap2", 0, 0, 1, 36'h0,         ONES,          0, 1, 0);
        add("inc_wrap2", 0, 1, 0, 36'h0,         36'h0,         1, 0, 1);
        add("dec_one",   0, 0, 1, 36'h0,         ONES,          0, 1, 0);
        add("dec_plain", 0, 0, 1, 36'h0,         ONES - 36'h1,  0, 0, 0);

        // Power-on reset state, with enables active.
        drive(1'b0, 1'b1, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("por", 36'h0, 0, 0, 1);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;

        // Vector table.
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].set, vecs[k].inc, vecs[k].dec, vecs[k].d);
            step();
            chk_all(vecs[k].name, vecs[k].q, vecs[k].c, vecs[k].b, vecs[k].z);
        end

        // Async reset from a loaded value, between clock edges.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 36'h123456789);
        step();
        chk("pre_rst.Q", bus.Q, 36'h123456789);
        drive(1'b0, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 36'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        // Async reset clears a pending carry pulse immediately.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, ONES);
        step();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        chk("carry_pre.carry", {35'd0, bus.carry}, 36'd1);
        drive(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk_all("rst_carry", 36'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-count with inc held, then count resumes from 0.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0);
        step();
        step();
        chk("midcnt.Q", bus.Q, 36'h2);
        #2;
        rst = 1'b1;
        #1;
        chk_all("midcnt_rst", 36'h0, 0, 0, 1);
        step();
        chk_all("rst_held", 36'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("resume_%0d.Q", n), bus.Q, W'(n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
